// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the controller state encoding and the register-index helpers.
package hazard_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } hazard_state_e;

  // x0 is hardwired to zero, so a load targeting it can never create a hazard.
  function automatic logic loadUseHazard(
    input logic                 exMemRead,
    input logic [REG_IDX_W-1:0] exRd,
    input logic [REG_IDX_W-1:0] idRs1,
    input logic [REG_IDX_W-1:0] idRs2,
    input logic                 idUsesRs1,
    input logic                 idUsesRs2
  );
    return exMemRead && (exRd != REG_X0) &&
           ((idUsesRs1 && (idRs1 == exRd)) || (idUsesRs2 && (idRs2 == exRd)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance statistics.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] countQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      countQ <= '0;
    end else if (inc_i && (countQ != {CNT_W{1'b1}})) begin
      countQ <= countQ + CNT_W'(1);
    end
  end

  assign count_o = countQ;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: drives stage enables/flushes from load-use,
// branch and memory-busy conditions, and keeps stall/flush/wait statistics.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RST_HOLD_CYCLES = 2,
  parameter int WAIT_TIMEOUT    = 255,
  parameter int CNT_W           = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] idRs1,
  input  logic [REG_IDX_W-1:0] idRs2,
  input  logic                 idUsesRs1,
  input  logic                 idUsesRs2,
  input  logic                 exMemRead,
  input  logic [REG_IDX_W-1:0] exRd,
  input  logic                 branchTaken,
  input  logic                 memBusy,
  output logic                 pcEn,
  output logic                 ifidEn,
  output logic                 ifidFlush,
  output logic                 idexEn,
  output logic                 idexFlush,
  output logic                 exmemEn,
  output logic [CNT_W-1:0]     stallCount,
  output logic [CNT_W-1:0]     flushCount,
  output logic [CNT_W-1:0]     waitCount,
  output logic                 timeoutErr
);

  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam int WAIT_W = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(WAIT_TIMEOUT);

  hazard_state_e     stateQ, stateD;
  logic [HOLD_W-1:0] holdCntQ, holdCntD;
  logic [WAIT_W-1:0] waitCntQ, waitCntD;
  logic              timeoutErrQ, timeoutErrD;
  logic              incStall, incFlush, incWait;
  logic              loadUse;

  assign loadUse = loadUseHazard(exMemRead, exRd, idRs1, idRs2, idUsesRs1, idUsesRs2);

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ      <= ST_HOLD;
      holdCntQ    <= HOLD_INIT;
      waitCntQ    <= '0;
      timeoutErrQ <= 1'b0;
    end else begin
      stateQ      <= stateD;
      holdCntQ    <= holdCntD;
      waitCntQ    <= waitCntD;
      timeoutErrQ <= timeoutErrD;
    end
  end

  // Mealy control: enables/flushes react in the same cycle as the hazard.
  always_comb begin
    stateD      = stateQ;
    holdCntD    = holdCntQ;
    waitCntD    = waitCntQ;
    timeoutErrD = timeoutErrQ;
    pcEn        = 1'b1;
    ifidEn      = 1'b1;
    idexEn      = 1'b1;
    exmemEn     = 1'b1;
    ifidFlush   = 1'b0;
    idexFlush   = 1'b0;
    incStall    = 1'b0;
    incFlush    = 1'b0;
    incWait     = 1'b0;

    if (rst || (stateQ == ST_HOLD)) begin
      pcEn      = 1'b0;
      ifidEn    = 1'b0;
      idexEn    = 1'b0;
      exmemEn   = 1'b0;
      ifidFlush = 1'b1;
      idexFlush = 1'b1;
      if (holdCntQ == '0) begin
        stateD = ST_RUN;
      end else begin
        holdCntD = holdCntQ - HOLD_W'(1);
      end
    end else if (memBusy) begin
      pcEn    = 1'b0;
      ifidEn  = 1'b0;
      idexEn  = 1'b0;
      exmemEn = 1'b0;
      incWait = 1'b1;
      stateD  = ST_WAIT;
      if (stateQ != ST_WAIT) begin
        waitCntD = WAIT_W'(1);
      end else if (waitCntQ < WAIT_MAX) begin
        waitCntD = waitCntQ + WAIT_W'(1);
      end
      if (waitCntD >= WAIT_MAX) begin
        timeoutErrD = 1'b1;
      end
    end else begin
      stateD   = ST_RUN;
      waitCntD = '0;
      // A load-use behind a taken branch is dropped: that instruction is flushed.
      if (branchTaken) begin
        ifidFlush = 1'b1;
        idexFlush = 1'b1;
        incFlush  = 1'b1;
      end else if (loadUse) begin
        pcEn      = 1'b0;
        ifidEn    = 1'b0;
        idexFlush = 1'b1;
        incStall  = 1'b1;
      end
    end
  end

  assign timeoutErr = timeoutErrQ;

  sat_counter #(.CNT_W(CNT_W)) uStallCnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (incStall),
    .count_o (stallCount)
  );

  sat_counter #(.CNT_W(CNT_W)) uFlushCnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (incFlush),
    .count_o (flushCount)
  );

  sat_counter #(.CNT_W(CNT_W)) uWaitCnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (incWait),
    .count_o (waitCount)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl with small timeout and counter widths
// so the timeout and saturation corners are reachable quickly.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] idRs1, idRs2, exRd;
  logic       idUsesRs1, idUsesRs2, exMemRead, branchTaken, memBusy;
  logic       pcEn, ifidEn, ifidFlush, idexEn, idexFlush, exmemEn;
  logic [3:0] stallCount, flushCount, waitCount;
  logic       timeoutErr;

  int errors = 0;
  int checks = 0;

  hazard_ctrl #(
    .RST_HOLD_CYCLES (2),
    .WAIT_TIMEOUT    (3),
    .CNT_W           (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .idRs1       (idRs1),
    .idRs2       (idRs2),
    .idUsesRs1   (idUsesRs1),
    .idUsesRs2   (idUsesRs2),
    .exMemRead   (exMemRead),
    .exRd        (exRd),
    .branchTaken (branchTaken),
    .memBusy     (memBusy),
    .pcEn        (pcEn),
    .ifidEn      (ifidEn),
    .ifidFlush   (ifidFlush),
    .idexEn      (idexEn),
    .idexFlush   (idexFlush),
    .exmemEn     (exmemEn),
    .stallCount  (stallCount),
    .flushCount  (flushCount),
    .waitCount   (waitCount),
    .timeoutErr  (timeoutErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic use1, input logic br, input logic busy);
    exMemRead   = ld;
    exRd        = rd;
    idRs1       = rs1;
    idUsesRs1   = use1;
    idRs2       = 5'd0;
    idUsesRs2   = 1'b0;
    branchTaken = br;
    memBusy     = busy;
  endtask

  task automatic toNegedge();
    @(negedge clk);
  endtask

  task automatic toAfterPosedge();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset and sit out the two hold cycles, ending in RUN.
  task automatic doReset();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    toAfterPosedge();
    rst = 1'b0;
    toAfterPosedge();
    toAfterPosedge();
  endtask

  initial begin
    int expStall;
    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    toAfterPosedge();
    toAfterPosedge();

    // Reset state
    checkOutput("rst_pcEn", 32'(pcEn), 0);
    checkOutput("rst_ifidFlush", 32'(ifidFlush), 1);
    checkOutput("rst_idexFlush", 32'(idexFlush), 1);
    checkOutput("rst_stall", 32'(stallCount), 0);
    checkOutput("rst_timeout", 32'(timeoutErr), 0);

    // Hold for exactly two cycles, inputs ignored
    rst = 1'b0;
    applyStimulus(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
    toNegedge();
    checkOutput("hold1_pcEn", 32'(pcEn), 0);
    checkOutput("hold1_idexFlush", 32'(idexFlush), 1);
    toAfterPosedge();
    toNegedge();
    checkOutput("hold2_pcEn", 32'(pcEn), 0);
    checkOutput("hold2_ifidFlush", 32'(ifidFlush), 1);
    toAfterPosedge();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    toNegedge();
    checkOutput("run_pcEn", 32'(pcEn), 1);
    checkOutput("run_ifidFlush", 32'(ifidFlush), 0);
    checkOutput("run_idexFlush", 32'(idexFlush), 0);
    checkOutput("hold_no_count", 32'(flushCount), 0);
    toAfterPosedge();

    // Load-use stall
    applyStimulus(1'b1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
    toNegedge();
    checkOutput("lu_pcEn", 32'(pcEn), 0);
    checkOutput("lu_ifidEn", 32'(ifidEn), 0);
    checkOutput("lu_idexEn", 32'(idexEn), 1);
    checkOutput("lu_idexFlush", 32'(idexFlush), 1);
    checkOutput("lu_exmemEn", 32'(exmemEn), 1);
    toAfterPosedge();
    checkOutput("lu_stallCount", 32'(stallCount), 1);

    // Load into x0 is not a hazard
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    toNegedge();
    checkOutput("x0_pcEn", 32'(pcEn), 1);
    checkOutput("x0_idexFlush", 32'(idexFlush), 0);
    toAfterPosedge();
    checkOutput("x0_stallCount", 32'(stallCount), 1);

    // Branch wins over load-use
    applyStimulus(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
    toNegedge();
    checkOutput("br_pcEn", 32'(pcEn), 1);
    checkOutput("br_ifidFlush", 32'(ifidFlush), 1);
    checkOutput("br_idexFlush", 32'(idexFlush), 1);
    toAfterPosedge();
    checkOutput("br_flushCount", 32'(flushCount), 1);
    checkOutput("br_stallCount", 32'(stallCount), 1);

    // memBusy with pending branch: freeze 4 cycles, then flush
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
      toNegedge();
      checkOutput("busy_pcEn", 32'(pcEn), 0);
      checkOutput("busy_exmemEn", 32'(exmemEn), 0);
      checkOutput("busy_ifidFlush", 32'(ifidFlush), 0);
      toAfterPosedge();
    end
    checkOutput("busy_waitCount", 32'(waitCount), 4);
    checkOutput("busy_flushCount", 32'(flushCount), 0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    toNegedge();
    checkOutput("wexit_pcEn", 32'(pcEn), 1);
    checkOutput("wexit_ifidFlush", 32'(ifidFlush), 1);
    toAfterPosedge();
    checkOutput("wexit_flushCount", 32'(flushCount), 1);
    checkOutput("wexit_waitCount", 32'(waitCount), 4);

    // Timeout after the third consecutive busy cycle, sticky until reset
    doReset();
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      toAfterPosedge();
      checkOutput("to_timeoutErr", 32'(timeoutErr), (i >= 3) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    toNegedge();
    checkOutput("to_resume_pcEn", 32'(pcEn), 1);
    toAfterPosedge();
    checkOutput("to_sticky", 32'(timeoutErr), 1);

    // Reset asserted mid-wait forces hold outputs immediately
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    toAfterPosedge();
    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    toNegedge();
    checkOutput("rstw_idexFlush", 32'(idexFlush), 1);
    checkOutput("rstw_pcEn", 32'(pcEn), 0);
    toAfterPosedge();
    checkOutput("rstw_timeout", 32'(timeoutErr), 0);
    checkOutput("rstw_waitCount", 32'(waitCount), 0);
    rst = 1'b0;
    toAfterPosedge();
    toAfterPosedge();

    // Stall counter saturates at 15
    expStall = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0);
      toAfterPosedge();
      expStall = (expStall == 15) ? 15 : expStall + 1;
      checkOutput("sat_stallCount", 32'(stallCount), 32'(expStall));
    end
    checkOutput("sat_final", 32'(stallCount), 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
